// File: rtl/cfg_loader.sv
// Bitstream loader for a switchbox configuration scan chain: fetches WORD_W-bit words,
// shifts them MSB-first into the chain, then holds the chain locked for a settle period.
module cfg_loader #(
    parameter int CHAIN_LEN  = 256,
    parameter int WORD_W     = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                word_data,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic                             cfg_dout,
    output logic                             cfg_shift,
    output logic                             cfg_lock,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CHAIN_FULL  = CW'(CHAIN_LEN);
    localparam logic [WW-1:0] WORD_LAST   = WW'(WORD_W);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   sreg_r, sreg_s;
    logic [WW-1:0]       wbits_r, wbits_s;
    logic [SW-1:0]       settle_r, settle_s;
    logic [CW-1:0]       bit_count_r, bit_count_s;
    logic                word_ready_r, word_ready_s;
    logic                dout_r, dout_s;
    logic                shift_r, shift_s;
    logic                lock_r, lock_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;

    // Next-state and next-output decode; outputs are computed for the state being entered
    always_comb begin
        state_s     = state_r;
        sreg_s      = sreg_r;
        wbits_s     = wbits_r;
        settle_s    = settle_r;
        bit_count_s = bit_count_r;
        dout_s      = 1'b0;
        shift_s     = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s     = FETCH;
                    bit_count_s = {CW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_s     = IDLE;
                    bit_count_s = {CW{1'b0}};
                    sreg_s      = {WORD_W{1'b0}};
                end else if (word_valid && word_ready_r) begin
                    // The first bit goes out on the cycle right after acceptance
                    state_s     = SHIFT;
                    dout_s      = word_data[WORD_W-1];
                    shift_s     = 1'b1;
                    sreg_s      = word_data << 1;
                    wbits_s     = WW'(1);
                    bit_count_s = bit_count_r + CW'(1);
                end else begin
                    state_s = FETCH;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_s     = IDLE;
                    bit_count_s = {CW{1'b0}};
                    sreg_s      = {WORD_W{1'b0}};
                end else if ((wbits_r == WORD_LAST) || (bit_count_r == CHAIN_FULL)) begin
                    // Leftover low bits of a final partial word are simply never shifted
                    if (bit_count_r == CHAIN_FULL) begin
                        settle_s = {SW{1'b0}};
                        if (SETTLE_CYC == 0) begin
                            state_s = DONE;
                        end else begin
                            state_s = SETTLE;
                        end
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s     = SHIFT;
                    dout_s      = sreg_r[WORD_W-1];
                    shift_s     = 1'b1;
                    sreg_s      = sreg_r << 1;
                    wbits_s     = wbits_r + WW'(1);
                    bit_count_s = bit_count_r + CW'(1);
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_s     = IDLE;
                    bit_count_s = {CW{1'b0}};
                    sreg_s      = {WORD_W{1'b0}};
                end else if (settle_r == SETTLE_LAST) begin
                    state_s = DONE;
                end else begin
                    settle_s = settle_r + SW'(1);
                end
            end
            default: begin
                state_s     = IDLE;
                bit_count_s = {CW{1'b0}};
                sreg_s      = {WORD_W{1'b0}};
            end
        endcase

        word_ready_s = (state_s == FETCH);
        busy_s       = (state_s == FETCH) || (state_s == SHIFT) || (state_s == SETTLE);
        done_s       = (state_s == DONE);
        lock_s       = (state_s != DONE);
    end

    // State and registered outputs; reset leaves the chain locked and quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            sreg_r       <= {WORD_W{1'b0}};
            wbits_r      <= {WW{1'b0}};
            settle_r     <= {SW{1'b0}};
            bit_count_r  <= {CW{1'b0}};
            word_ready_r <= 1'b0;
            dout_r       <= 1'b0;
            shift_r      <= 1'b0;
            lock_r       <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sreg_r       <= sreg_s;
            wbits_r      <= wbits_s;
            settle_r     <= settle_s;
            bit_count_r  <= bit_count_s;
            word_ready_r <= word_ready_s;
            dout_r       <= dout_s;
            shift_r      <= shift_s;
            lock_r       <= lock_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign word_ready = word_ready_r;
    assign cfg_dout   = dout_r;
    assign cfg_shift  = shift_r;
    assign cfg_lock   = lock_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign bit_count  = bit_count_r;

endmodule
